// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
// Scoreboard entry layout and forwarding select encodings.
package hazard_pkg;

  localparam int MAX_REG_ADDR_W = 8;

  localparam int FWD_RF      = 0;
  localparam int FWD_EXE_MEM = 1;
  localparam int FWD_MEM_WB  = 2;

  typedef struct packed {
    logic                      valid;
    logic [MAX_REG_ADDR_W-1:0] rd;
    logic                      reg_write;
    logic                      mem_read;
  } sb_entry_t;

  function automatic int sel_w(input int fwd_stages);
    return $clog2(fwd_stages + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments when enabled and inc is high,
// sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (enable && inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard and forwarding controller for the 5-stage core: shift-register
// scoreboard of in-flight writers, load-use stall, forwarding, flush.
module pipe_hazard_unit
  import hazard_pkg::*;
#(
  parameter int NUM_SRC       = 2,
  parameter int REG_ADDR_W    = 5,
  parameter int FWD_STAGES    = 2,
  parameter int LOAD_LAT      = 1,
  parameter int RESOLVE_STAGE = 3,
  parameter int CNT_W         = 32,
  localparam int SEL_W        = sel_w(FWD_STAGES)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs_addr,
  input  logic [NUM_SRC-1:0]            id_rs_used,
  input  logic [REG_ADDR_W-1:0]         id_rd_addr,
  input  logic                          id_reg_write,
  input  logic                          id_mem_read,
  input  logic                          redirect,
  output logic                          stall,
  output logic                          bubble,
  output logic [RESOLVE_STAGE-2:0]      flush,
  output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
  output logic [NUM_SRC-1:0]            id_bypass,
  output logic [CNT_W-1:0]              stall_cnt,
  output logic [CNT_W-1:0]              flush_cnt
);

  sb_entry_t sb_q [FWD_STAGES+1];
  sb_entry_t id_entry;

  logic                     load_use;
  logic [NUM_SRC*SEL_W-1:0] fwd_nxt;
  logic [NUM_SRC-1:0]       byp_raw;

  always_comb begin
    id_entry           = '0;
    id_entry.valid     = id_valid;
    id_entry.rd        = MAX_REG_ADDR_W'(id_rd_addr);
    id_entry.reg_write = id_reg_write;
    id_entry.mem_read  = id_mem_read;
  end

  // Youngest match wins; a WB-only match becomes an ID bypass.
  always_comb begin
    load_use = 1'b0;
    fwd_nxt  = '0;
    byp_raw  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin : g_src
      logic [REG_ADDR_W-1:0] rs;
      logic                  found;
      logic                  m;
      rs    = id_rs_addr[i*REG_ADDR_W +: REG_ADDR_W];
      found = 1'b0;
      fwd_nxt[i*SEL_W +: SEL_W] = SEL_W'(FWD_RF);
      for (int d = 0; d <= FWD_STAGES; d++) begin
        m = sb_q[d].valid && sb_q[d].reg_write &&
            id_rs_used[i] && (rs != '0) &&
            (sb_q[d].rd == MAX_REG_ADDR_W'(rs));
        if (m && (d < LOAD_LAT) && sb_q[d].mem_read) begin
          load_use = 1'b1;
        end
        if (m && !found) begin
          found = 1'b1;
          if (d < FWD_STAGES) begin
            fwd_nxt[i*SEL_W +: SEL_W] = SEL_W'(FWD_EXE_MEM + d);
          end else begin
            byp_raw[i] = 1'b1;
          end
        end
      end
    end
  end

  assign stall     = enable && load_use && !redirect;
  assign bubble    = stall;
  assign flush     = {(RESOLVE_STAGE-1){enable && redirect}};
  assign id_bypass = enable ? byp_raw : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int d = 0; d <= FWD_STAGES; d++) begin
        sb_q[d] <= '0;
      end
      fwd_sel <= '0;
    end else if (enable) begin
      sb_q[0] <= (stall || redirect) ? '0 : id_entry;
      // Stages younger than the resolve point are squashed on redirect.
      for (int d = 0; d < FWD_STAGES; d++) begin
        sb_q[d+1] <= (redirect && (2 + d < RESOLVE_STAGE)) ?
                     '0 : sb_q[d];
      end
      fwd_sel <= redirect ? '0 : fwd_nxt;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .inc    (stall),
    .cnt    (stall_cnt)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .inc    (redirect),
    .cnt    (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit: sequential vector table plus
// counter saturation and reset-during-stall sequences.
module tb_pipe_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       id_valid;
  logic [9:0] id_rs_addr;
  logic [1:0] id_rs_used;
  logic [4:0] id_rd_addr;
  logic       id_reg_write;
  logic       id_mem_read;
  logic       redirect;
  logic       stall;
  logic       bubble;
  logic [2:0] flush;
  logic [3:0] fwd_sel;
  logic [1:0] id_bypass;
  logic [3:0] stall_cnt;
  logic [3:0] flush_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_hazard_unit #(
    .NUM_SRC       (2),
    .REG_ADDR_W    (5),
    .FWD_STAGES    (2),
    .LOAD_LAT      (1),
    .RESOLVE_STAGE (4),
    .CNT_W         (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .id_valid     (id_valid),
    .id_rs_addr   (id_rs_addr),
    .id_rs_used   (id_rs_used),
    .id_rd_addr   (id_rd_addr),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .redirect     (redirect),
    .stall        (stall),
    .bubble       (bubble),
    .flush        (flush),
    .fwd_sel      (fwd_sel),
    .id_bypass    (id_bypass),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  typedef struct {
    logic       en;
    logic       vld;
    logic [4:0] rs0;
    logic [4:0] rs1;
    logic [1:0] used;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic       redir;
    logic       e_stall;
    logic [2:0] e_flush;
    logic [1:0] e_byp;
    logic [3:0] e_fwd;
    logic [3:0] e_scnt;
    logic [3:0] e_fcnt;
  } vec_t;

  localparam int NV = 27;
  vec_t tbl [NV];

  function automatic vec_t mk(
    input logic en, vld,
    input logic [4:0] rs0, rs1,
    input logic [1:0] used,
    input logic [4:0] rd,
    input logic rw, mr, redir, e_stall,
    input logic [2:0] e_flush,
    input logic [1:0] e_byp,
    input logic [3:0] e_fwd, e_scnt, e_fcnt
  );
    vec_t v;
    v.en = en; v.vld = vld; v.rs0 = rs0; v.rs1 = rs1;
    v.used = used; v.rd = rd; v.rw = rw; v.mr = mr;
    v.redir = redir; v.e_stall = e_stall; v.e_flush = e_flush;
    v.e_byp = e_byp; v.e_fwd = e_fwd;
    v.e_scnt = e_scnt; v.e_fcnt = e_fcnt;
    return v;
  endfunction

  function automatic vec_t nop(
    input logic [3:0] e_fwd, e_scnt, e_fcnt
  );
    return mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 3'b000, 2'b00,
              e_fwd, e_scnt, e_fcnt);
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    enable       = v.en;
    id_valid     = v.vld;
    id_rs_addr   = {v.rs1, v.rs0};
    id_rs_used   = v.used;
    id_rd_addr   = v.rd;
    id_reg_write = v.rw;
    id_mem_read  = v.mr;
    redirect     = v.redir;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(nop(0, 0, 0));
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // add r3,r1,r2 ; sub r4,r3,r5
    tbl[0]  = mk(1, 1, 1, 2, 2'b11, 3, 1, 0, 0, 0, 0, 0, 4'h0, 0, 0);
    tbl[1]  = mk(1, 1, 3, 5, 2'b11, 4, 1, 0, 0, 0, 0, 0, 4'h0, 0, 0);
    tbl[2]  = nop(4'h1, 0, 0);
    // lw r3,0(r1) ; add r4,r3,r3
    tbl[3]  = mk(1, 1, 1, 0, 2'b01, 3, 1, 1, 0, 0, 0, 0, 4'h0, 0, 0);
    tbl[4]  = mk(1, 1, 3, 3, 2'b11, 4, 1, 0, 0, 1, 0, 0, 4'h0, 0, 0);
    tbl[5]  = mk(1, 1, 3, 3, 2'b11, 4, 1, 0, 0, 0, 0, 0, 4'h5, 1, 0);
    tbl[6]  = nop(4'hA, 1, 0);
    // add r7 ; 2 slots ; consumer of r7 sees WB bypass
    tbl[7]  = mk(1, 1, 1, 2, 2'b11, 7, 1, 0, 0, 0, 0, 0, 4'h0, 1, 0);
    tbl[8]  = nop(4'h0, 1, 0);
    tbl[9]  = nop(4'h0, 1, 0);
    tbl[10] = mk(1, 1, 7, 0, 2'b11, 8, 1, 0, 0, 0, 0, 2'b01, 4'h0, 1, 0);
    tbl[11] = nop(4'h0, 1, 0);
    // lw r0 then consumers of r0
    tbl[12] = mk(1, 1, 1, 0, 2'b01, 0, 1, 1, 0, 0, 0, 0, 4'h0, 1, 0);
    tbl[13] = mk(1, 1, 0, 0, 2'b11, 5, 1, 0, 0, 0, 0, 0, 4'h0, 1, 0);
    tbl[14] = nop(4'h0, 1, 0);
    tbl[15] = mk(1, 1, 0, 0, 2'b11, 6, 1, 0, 0, 0, 0, 0, 4'h0, 1, 0);
    tbl[16] = nop(4'h0, 1, 0);
    // redirect with pending load-use
    tbl[17] = mk(1, 1, 1, 0, 2'b01, 3, 1, 1, 0, 0, 0, 0, 4'h0, 1, 0);
    tbl[18] = mk(1, 1, 3, 3, 2'b11, 4, 1, 0, 1, 0, 3'b111, 0, 4'h0, 1, 0);
    tbl[19] = nop(4'h0, 1, 1);
    // enable low freezes state and masks stall
    tbl[20] = mk(1, 1, 1, 1, 2'b11, 2, 1, 0, 0, 0, 0, 0, 4'h0, 1, 1);
    tbl[21] = mk(1, 1, 2, 0, 2'b01, 12, 1, 1, 0, 0, 0, 0, 4'h0, 1, 1);
    tbl[22] = mk(0, 1, 12, 12, 2'b11, 13, 1, 0, 0, 0, 0, 0, 4'h1, 1, 1);
    tbl[23] = mk(0, 1, 12, 12, 2'b11, 13, 1, 0, 0, 0, 0, 0, 4'h1, 1, 1);
    tbl[24] = mk(1, 1, 12, 12, 2'b11, 13, 1, 0, 0, 1, 0, 0, 4'h1, 1, 1);
    tbl[25] = mk(1, 1, 12, 12, 2'b11, 13, 1, 0, 0, 0, 0, 0, 4'h5, 2, 1);
    tbl[26] = nop(4'hA, 2, 1);

    rst = 1'b1;
    drive(nop(0, 0, 0));
    do_reset();
    #1;
    chk("rst stall", stall, 0);
    chk("rst bubble", bubble, 0);
    chk("rst flush", flush, 0);
    chk("rst bypass", id_bypass, 0);
    chk("rst fwd_sel", fwd_sel, 0);
    chk("rst stall_cnt", stall_cnt, 0);
    chk("rst flush_cnt", flush_cnt, 0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      chk($sformatf("v%0d stall", i), stall, tbl[i].e_stall);
      chk($sformatf("v%0d bubble", i), bubble, tbl[i].e_stall);
      chk($sformatf("v%0d flush", i), flush, tbl[i].e_flush);
      chk($sformatf("v%0d bypass", i), id_bypass, tbl[i].e_byp);
      chk($sformatf("v%0d fwd_sel", i), fwd_sel, tbl[i].e_fwd);
      chk($sformatf("v%0d stall_cnt", i), stall_cnt, tbl[i].e_scnt);
      chk($sformatf("v%0d flush_cnt", i), flush_cnt, tbl[i].e_fcnt);
    end

    // lw r3,0(r3) held in ID: stalls every other cycle, counter saturates
    do_reset();
    drive(mk(1, 1, 3, 0, 2'b01, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    for (int c = 0; c < 40; c++) begin
      #1;
      chk($sformatf("sat c%0d stall", c), stall, (c % 2) == 1);
      @(negedge clk);
    end
    #1;
    chk("sat stall_cnt", stall_cnt, 4'd15);
    @(negedge clk);
    #1;
    chk("mid stall", stall, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post-rst stall", stall, 0);
    chk("post-rst stall_cnt", stall_cnt, 0);
    chk("post-rst flush_cnt", flush_cnt, 0);
    chk("post-rst fwd_sel", fwd_sel, 0);
    @(negedge clk);
    #1;
    chk("post-rst restall", stall, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
